// File: rtl/dr_mem_arbiter.sv
// Two-port round-robin arbiter and four-phase dual-rail sequencer for the
// 16x8 asynchronous memory. One transaction runs at a time:
// IDLE -> DRIVE (valid codewords) -> SPACER (null) -> DONE (done pulse).
module dr_mem_arbiter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [3:0]  addr0,
  input  logic [3:0]  addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rdata,
  output logic        err,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_data_in,
  output logic [1:0]  mem_read_Nwrite,
  output logic        mem_ack_in_read,
  input  logic [15:0] mem_data_out,
  input  logic        mem_ack_read,
  input  logic        mem_ack_write
);

  // Last counter value before the wait is abandoned.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StSpacer, StDone} state_e;

  // Dual-rail: true rail at 2i+1, false rail at 2i.
  function automatic logic [7:0] enc_addr(input logic [3:0] a);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = a[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [15:0] enc_data(input logic [7:0] d);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [7:0] dec_data(input logic [15:0] w);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = w[2*i+1];
    return r;
  endfunction

  // A pair is a legal data bit only when exactly one rail is high.
  function automatic logic pairs_valid(input logic [15:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) if (w[2*i+1] == w[2*i]) ok = 1'b0;
    return ok;
  endfunction

  logic [SYNC_STAGES-1:0] ack_rd_sync_q;
  logic [SYNC_STAGES-1:0] ack_wr_sync_q;
  state_e                 state_q;
  logic                   gnt_q;
  logic                   last_q;
  logic                   we_q;
  logic [7:0]             cnt_q;

  logic       ack_rd;
  logic       ack_wr;
  logic       ack_cur;
  logic       gnt_sel;
  logic       sel_we;
  logic [3:0] sel_addr;
  logic [7:0] sel_wdata;

  // Independent synchronizer chains for the two asynchronous acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_rd_sync_q <= '0;
      ack_wr_sync_q <= '0;
    end else begin
      ack_rd_sync_q <= {ack_rd_sync_q[SYNC_STAGES-2:0], mem_ack_read};
      ack_wr_sync_q <= {ack_wr_sync_q[SYNC_STAGES-2:0], mem_ack_write};
    end
  end

  // Round-robin choice and the request fields of the chosen port.
  always_comb begin
    ack_rd  = ack_rd_sync_q[SYNC_STAGES-1];
    ack_wr  = ack_wr_sync_q[SYNC_STAGES-1];
    ack_cur = we_q ? ack_wr : ack_rd;
    if (req0 && req1) gnt_sel = ~last_q;
    else              gnt_sel = req1;
    sel_we    = gnt_sel ? we1    : we0;
    sel_addr  = gnt_sel ? addr1  : addr0;
    sel_wdata = gnt_sel ? wdata1 : wdata0;
  end

  // Sequencer FSM; every memory-side and port-side output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      gnt_q           <= 1'b0;
      last_q          <= 1'b1;
      we_q            <= 1'b0;
      cnt_q           <= '0;
      done0           <= 1'b0;
      done1           <= 1'b0;
      rdata           <= '0;
      err             <= 1'b0;
      mem_addr        <= '0;
      mem_data_in     <= '0;
      mem_read_Nwrite <= '0;
      mem_ack_in_read <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          mem_addr        <= '0;
          mem_data_in     <= '0;
          mem_read_Nwrite <= '0;
          if (req0 || req1) begin
            gnt_q    <= gnt_sel;
            last_q   <= gnt_sel;
            we_q     <= sel_we;
            err      <= 1'b0;
            cnt_q    <= '0;
            mem_addr <= enc_addr(sel_addr);
            if (sel_we) begin
              mem_data_in     <= enc_data(sel_wdata);
              mem_read_Nwrite <= 2'b01;
            end else begin
              mem_read_Nwrite <= 2'b10;
            end
            state_q <= StDrive;
          end
        end
        StDrive: begin
          // A real ack wins over a timeout landing in the same cycle.
          if (ack_cur || cnt_q == TimeoutLast) begin
            if (!ack_cur) begin
              err <= 1'b1;
            end else if (!we_q) begin
              rdata           <= dec_data(mem_data_out);
              err             <= ~pairs_valid(mem_data_out);
              mem_ack_in_read <= 1'b1;
            end
            mem_addr        <= '0;
            mem_data_in     <= '0;
            mem_read_Nwrite <= '0;
            cnt_q           <= '0;
            state_q         <= StSpacer;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StSpacer: begin
          if (!ack_cur || cnt_q == TimeoutLast) begin
            if (ack_cur) err <= 1'b1;
            mem_ack_in_read <= 1'b0;
            done0           <= ~gnt_q;
            done1           <= gnt_q;
            state_q         <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
